// File: rtl/twd_gen_if.sv
// ============================================================================
// Module : twd_gen_if
// Brief  : Control, configuration, stream and table-read bundle for twd_gen.
//          Table read signals exist only when TWD_TABLE_EN is defined.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface twd_gen_if #(
  parameter int W    = 8,
  parameter int LOGN = 3
);
  logic            start;
  logic [W-1:0]    cfg_mod;
  logic [W-1:0]    cfg_root;
  logic            busy;
  logic            done;
  logic            err;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    out_data;
  logic [LOGN-1:0] out_i;
  logic [LOGN-1:0] out_j;
`ifdef TWD_TABLE_EN
  logic [LOGN-1:0] rd_i;
  logic [LOGN-1:0] rd_j;
  logic [W-1:0]    rd_data;

  modport master (
    output start, cfg_mod, cfg_root, out_ready, rd_i, rd_j,
    input  busy, done, err, out_valid, out_data, out_i, out_j, rd_data
  );
  modport slave (
    input  start, cfg_mod, cfg_root, out_ready, rd_i, rd_j,
    output busy, done, err, out_valid, out_data, out_i, out_j, rd_data
  );
`else
  modport master (
    output start, cfg_mod, cfg_root, out_ready,
    input  busy, done, err, out_valid, out_data, out_i, out_j
  );
  modport slave (
    input  start, cfg_mod, cfg_root, out_ready,
    output busy, done, err, out_valid, out_data, out_i, out_j
  );
`endif
endinterface

`default_nettype wire

// File: rtl/twd_gen.sv
// ============================================================================
// Module : twd_gen
// Brief  : Run-time twiddle table generator, Twf[i][j] = root^(i*j) mod q,
//          streamed row-major; optional readable table via TWD_TABLE_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module twd_gen #(
  parameter int N    = 8,
  parameter int W    = 8,
  parameter int LOGN = $clog2(N)
) (
  input  logic     clk,
  input  logic     rst,
  twd_gen_if.slave bus
);

  localparam logic [LOGN-1:0] LAST = LOGN'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    q_q, q_d;
  logic [W-1:0]    r_q, r_d;
  logic [W-1:0]    rowstep_q, rowstep_d;
  logic [W-1:0]    power_q, power_d;
  logic [LOGN-1:0] i_q, i_d;
  logic [LOGN-1:0] j_q, j_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            valid_q, valid_d;

  logic            hs;
  logic            last_col;
  logic            cfg_bad;
  logic [W-1:0]    mul_a;
  logic [W-1:0]    mul_b;
  logic [2*W-1:0]  prod;
  logic [W-1:0]    mul_res;
  logic [W-1:0]    root_red;

  assign hs       = valid_q & bus.out_ready;
  assign last_col = (j_q == LAST);
  assign cfg_bad  = (bus.cfg_mod < W'(2));

  // One shared multiplier: the column step normally, the row step on the last column.
  always_comb begin
    mul_a    = last_col ? rowstep_q : power_q;
    mul_b    = last_col ? r_q       : rowstep_q;
    prod     = {{W{1'b0}}, mul_a} * {{W{1'b0}}, mul_b};
    mul_res  = (q_q < W'(2)) ? '0 : W'(prod % {{W{1'b0}}, q_q});
    root_red = cfg_bad ? '0 : (bus.cfg_root % bus.cfg_mod);
  end

  always_comb begin
    state_d   = state_q;
    q_d       = q_q;
    r_d       = r_q;
    rowstep_d = rowstep_q;
    power_d   = power_q;
    i_d       = i_q;
    j_d       = j_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;
    valid_d   = valid_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          q_d    = bus.cfg_mod;
          r_d    = root_red;
          busy_d = 1'b1;
          err_d  = cfg_bad;
          if (cfg_bad) begin
            state_d = DONE;
          end else begin
            state_d   = EMIT;
            valid_d   = 1'b1;
            i_d       = '0;
            j_d       = '0;
            rowstep_d = W'(1);
            power_d   = W'(1);
          end
        end
      end
      EMIT: begin
        if (hs) begin
          if (!last_col) begin
            power_d = mul_res;
            j_d     = j_q + LOGN'(1);
          end else if (i_q != LAST) begin
            rowstep_d = mul_res;
            power_d   = W'(1);
            j_d       = '0;
            i_d       = i_q + LOGN'(1);
          end else begin
            state_d = DONE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      DONE: begin
        // Entered still busy only on a bad modulus: spend one cycle before the pulse.
        busy_d = 1'b0;
        done_d = busy_q;
        if (!busy_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      q_q       <= '0;
      r_q       <= '0;
      rowstep_q <= '0;
      power_q   <= '0;
      i_q       <= '0;
      j_q       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      q_q       <= q_d;
      r_q       <= r_d;
      rowstep_q <= rowstep_d;
      power_q   <= power_d;
      i_q       <= i_d;
      j_q       <= j_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      valid_q   <= valid_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = power_q;
  assign bus.out_i     = i_q;
  assign bus.out_j     = j_q;

`ifdef TWD_TABLE_EN
  logic [W-1:0] table_q [N*N];
  logic [W-1:0] rd_data_q;

  // Storage is deliberately unreset; contents persist until overwritten.
  always_ff @(posedge clk) begin
    if (hs) table_q[{i_q, j_q}] <= power_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= table_q[{bus.rd_i, bus.rd_j}];
  end

  assign bus.rd_data = rd_data_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_twd_gen.sv
// ============================================================================
// Module : tb_twd_gen
// Brief  : Self-checking bench for twd_gen against a modular-power model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_twd_gen;
  localparam int N    = 8;
  localparam int W    = 8;
  localparam int LOGN = 3;
  localparam int NN   = N * N;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  twd_gen_if #(.W(W), .LOGN(LOGN)) bus ();
  twd_gen #(.N(N), .W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  int got  [NN];
  int dflt [NN];
  int expv [NN];

  typedef struct {
    int i;
    int j;
    int val;
  } vec_t;
  vec_t vecs [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic int modpow(input int q, input int b, input int e);
    longint acc = 1;
    longint base = longint'(b % q);
    for (int k = 0; k < e; k++) acc = (acc * base) % q;
    return int'(acc);
  endfunction

  // One generation: glitch_hs pulses start mid-stream, abort_hs resets mid-stream.
  task automatic run(input int q, input int root, input bit rnd,
                     input int glitch_hs, input int abort_hs);
    int hs, c, pd, pi, pj;
    bit fin, stalled, rdy;
    for (int k = 0; k < NN; k++) expv[k] = modpow(q, root, (k / N) * (k % N));
    bus.start = 1'b1; bus.cfg_mod = W'(q); bus.cfg_root = W'(root);
    tick();
    bus.start = 1'b0;
    check("busy_t1", bus.busy, 1);
    check("valid_t1", bus.out_valid, 1);
    check("data_t1", bus.out_data, 1);
    check("err_t1", bus.err, 0);
    hs = 0; c = 1; fin = 0; stalled = 0; pd = 0; pi = 0; pj = 0;
    while (!fin && c < 4000) begin
      if (abort_hs >= 0 && hs == abort_hs) begin
        rst = 1'b1;
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_err", bus.err, 0);
        check("rst_valid", bus.out_valid, 0);
        check("rst_data", bus.out_data, 0);
        check("rst_i", bus.out_i, 0);
        check("rst_j", bus.out_j, 0);
`ifdef TWD_TABLE_EN
        check("rst_rd_data", bus.rd_data, 0);
`endif
        for (int k = 0; k < 3; k++) begin
          tick();
          check("rst_no_done", bus.done, 0);
        end
        rst = 1'b0;
        tick();
        check("post_rst_valid", bus.out_valid, 0);
        return;
      end
      if (bus.done) begin
        fin = 1;
      end else begin
        if (!bus.out_valid) check("valid_hold", bus.out_valid, 1);
        if (stalled) begin
          check("stall_data", bus.out_data, pd);
          check("stall_i", bus.out_i, pi);
          check("stall_j", bus.out_j, pj);
        end
        bus.start = (hs == glitch_hs);
        if (bus.start) begin
          bus.cfg_mod = W'(5); bus.cfg_root = W'(2);
        end
        rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.out_ready = rdy;
        if (bus.out_valid && rdy) begin
          if (hs >= NN) begin
            check("extra_hs", hs, NN - 1);
          end else begin
            check("hs_i", bus.out_i, hs / N);
            check("hs_j", bus.out_j, hs % N);
            check("hs_data", bus.out_data, expv[hs]);
            got[hs] = int'(bus.out_data);
          end
          hs++;
        end
        stalled = bus.out_valid && !rdy;
        pd = int'(bus.out_data); pi = int'(bus.out_i); pj = int'(bus.out_j);
        tick();
        c++;
      end
    end
    bus.start = 1'b0;
    bus.out_ready = 1'b1;
    check("done_seen", fin, 1);
    check("hs_count", hs, NN);
    if (!rnd) check("done_cycle", c, NN + 1);
    check("done_busy", bus.busy, 0);
    check("done_valid", bus.out_valid, 0);
    tick();
    check("done_pulse", bus.done, 0);
    check("idle_busy", bus.busy, 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.cfg_mod = '0; bus.cfg_root = '0; bus.out_ready = 1'b0;
`ifdef TWD_TABLE_EN
    bus.rd_i = '0; bus.rd_j = '0;
`endif
    tick();
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_err", bus.err, 0);
    check("reset_valid", bus.out_valid, 0);
    check("reset_data", bus.out_data, 0);
    check("reset_ij", {bus.out_i, bus.out_j}, 0);
    tick();
    rst = 1'b0;
    tick();

    // Known entries of the q=17, root=9 table.
    vecs.push_back('{1, 0, 1});  vecs.push_back('{1, 1, 9});  vecs.push_back('{1, 2, 13});
    vecs.push_back('{1, 3, 15}); vecs.push_back('{1, 4, 16}); vecs.push_back('{1, 5, 8});
    vecs.push_back('{1, 6, 4});  vecs.push_back('{1, 7, 2});  vecs.push_back('{2, 1, 13});
    vecs.push_back('{2, 2, 16}); vecs.push_back('{2, 3, 4});  vecs.push_back('{2, 4, 1});
    vecs.push_back('{2, 5, 13}); vecs.push_back('{2, 7, 4});  vecs.push_back('{7, 7, 9});
    vecs.push_back('{0, 5, 1});  vecs.push_back('{6, 0, 1});

    run(17, 9, 1'b0, -1, -1);
    for (int k = 0; k < NN; k++) dflt[k] = got[k];
    foreach (vecs[v]) check($sformatf("vec_%0d_%0d", vecs[v].i, vecs[v].j),
                            dflt[vecs[v].i * N + vecs[v].j], vecs[v].val);

`ifdef TWD_TABLE_EN
    bus.rd_i = 3'd1; bus.rd_j = 3'd3; tick();
    check("rd_1_3", bus.rd_data, 15);
    bus.rd_i = 3'd2; bus.rd_j = 3'd4; tick();
    check("rd_2_4", bus.rd_data, 1);
    for (int k = 0; k < NN; k++) begin
      bus.rd_i = LOGN'(k / N); bus.rd_j = LOGN'(k % N);
      tick();
      check("rd_all", bus.rd_data, dflt[k]);
    end
`endif

    run(17, 26, 1'b0, -1, -1);
    for (int k = 0; k < NN; k++) check("root_red", got[k], dflt[k]);

    run(17, 9, 1'b1, -1, -1);
    for (int k = 0; k < NN; k++) check("bp_stream", got[k], dflt[k]);

    bus.start = 1'b1; bus.cfg_mod = W'(1); bus.cfg_root = W'(3);
    tick();
    bus.start = 1'b0;
    check("bad_busy_t1", bus.busy, 1);
    check("bad_err_t1", bus.err, 1);
    check("bad_valid_t1", bus.out_valid, 0);
    check("bad_done_t1", bus.done, 0);
    tick();
    check("bad_done_t2", bus.done, 1);
    check("bad_busy_t2", bus.busy, 0);
    check("bad_valid_t2", bus.out_valid, 0);
    tick();
    check("bad_done_t3", bus.done, 0);
    check("bad_err_sticky", bus.err, 1);
    check("bad_valid_t3", bus.out_valid, 0);

    run(17, 9, 1'b0, 10, -1);
    for (int k = 0; k < NN; k++) check("glitch_stream", got[k], dflt[k]);

    run(17, 9, 1'b0, -1, 20);
    run(17, 9, 1'b0, -1, -1);
    for (int k = 0; k < NN; k++) check("after_rst", got[k], dflt[k]);

    for (int t = 0; t < 4; t++) begin
      run(int'($urandom_range(2, 255)), int'($urandom_range(0, 255)), 1'b1, -1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/twd_gen.md
# twd_gen

Run-time twiddle-factor generator for the NTT datapath. After a `start` pulse it computes the full N×N table Twf[i][j] = root^(i·j) mod q, using a sequential modular multiplier. It replaces constant elaboration-time tables with a modulus and root that are loaded at run time. Entries stream out in row-major order over a valid/ready handshake to the butterfly array or a coefficient buffer; an optional internal table allows random-access reads afterwards.

## Interface
- `N`, 8, transform size; power of two, 2..64
- `W`, 8, coefficient width in bits; modulus and root are W-bit
- `LOGN`, $clog2(N), index width (derived; do not override)

- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  one-cycle request; sampled only when `busy`=0
- `cfg_mod`  in  W  modulus q; sampled with `start`
- `cfg_root`  in  W  root ω; sampled with `start`
- `busy`  out  1  high from the cycle after an accepted `start` until `done`
- `done`  out  1  one-cycle pulse at end of generation
- `err`  out  1  sticky flag, q<2; cleared by the next accepted `start`
- `out_valid`  out  1  entry available
- `out_ready`  in  1  consumer accepts entry
- `out_data`  out  W  Twf[out_i][out_j]
- `out_i`, `out_j`  out  LOGN  row and column of the current entry
- `rd_i`, `rd_j`  in  LOGN  table read address (TWD_TABLE_EN only)
- `rd_data`  out  W  registered table read data (TWD_TABLE_EN only)

## Operation
- Reset values of every output are 0: `busy`, `done`, `err`, `out_valid`, `out_data`, `out_i`, `out_j`, `rd_data`. The FSM resets to IDLE.
- FSM states: IDLE, EMIT, DONE.
- **IDLE, `start`=1:**
  - Latch q=`cfg_mod`.
  - Latch r=`cfg_root` mod q. Roots ≥ q are legal.
  - If q<2: set `err` and go to DONE; no entries are emitted.
  - Otherwise: i=0, j=0, rowstep=1, power=1; go to EMIT.
- **EMIT:**
  - `out_valid`=1 and `out_data`=power.
  - `out_data`, `out_i` and `out_j` hold stable until the handshake.
- **Handshake (`out_valid`&`out_ready`):**
  - Write power to table[i][j].
  - If j<N-1: power ← (power·rowstep) mod q; j++.
  - If j=N-1 and i<N-1: rowstep ← (rowstep·r) mod q; power ← 1; j ← 0; i++.
  - If j=N-1 and i=N-1: go to DONE; `out_valid` falls in the next cycle.
- **DONE:** `done`=1 for exactly one cycle, `busy` falls in the same cycle, then return to IDLE.
- `start` while `busy` is ignored, with no effect on the latched q and r.
- Arithmetic:
  - Operands are W-bit; the product is a full 2W-bit value reduced by `%` q to W bits.
  - Every stored and output value is < q.
  - With q≥2, the entry for i=0 or j=0 is exactly 1.
- Reset mid-operation aborts immediately: outputs go to reset values, no `done` pulse, table contents are undefined.

## Timing
- `start` accepted in cycle T → `busy`=1 and `out_valid`=1 at T+1 (first entry, value 1).
- Throughput is one entry per cycle while `out_ready`=1. With `out_ready` held high, N² handshakes occupy T+1..T+N².
- `done` pulses at T+N²+1.
- q<2: `busy`=1 and `err`=1 at T+1; `done` at T+2.
- Backpressure: every cycle with `out_ready`=0 in EMIT adds one cycle; no entry is dropped or duplicated.
- `out_ready` has no combinational path to `out_valid`.
- `rd_data` = table[`rd_i`][`rd_j`] one cycle after the address is presented.

## Configuration
- `TWD_TABLE_EN` defined:
  - An N²×W register table is written on each handshake.
  - Read ports `rd_i`, `rd_j`, `rd_data` exist.
  - The table keeps its contents across later IDLE periods until the next accepted `start` begins overwriting it.
  - A read of an entry not yet written in the current run returns its previous contents.
- `TWD_TABLE_EN` undefined:
  - No table storage and no read ports; streaming only.
  - All other behaviour is identical.

## Test plan
- **Default run:** N=8, q=17, ω=9, `out_ready`=1.
  - 64 entries; row 1 = 1,9,13,15,16,8,4,2; row 2 = 1,13,16,4,1,13,16,4.
  - Twf[7][7]=9.
  - `done` at T+65.
- **Root reduction:** ω=26, q=17 → stream is bit-identical to the default run.
- **Random backpressure:** `out_ready` random at 50% → exactly 64 handshakes in row-major order, values matching the default run; data stable while stalled.
- **Invalid modulus and ignored start:**
  - q=1 → `err`=1, `done` two cycles after `start`, `out_valid` never asserted.
  - A subsequent valid `start` clears `err`.
  - A `start` pulsed during `busy` → ignored; output unchanged.
- **Reset mid-stream:** assert `rst` after handshake 20 → all outputs 0 immediately, no `done`. A fresh `start` then reproduces the full default sequence from entry [0][0].
- **Table readback (TWD_TABLE_EN):** after the default run, read [1][3] → 15 and [2][4] → 1 one cycle after the address; read all 64 entries and compare with the stream.
